// File: rtl/rr_reg_arbiter_pkg.sv
// Shared constants and helpers for the round-robin register write arbiter.
// Imported by the interface, the pick sub-module and the top level.
package rr_reg_arbiter_pkg;

    localparam int N_DEF = 4;
    localparam int W_DEF = 8;

    // Upper bounds for the generic slice helper; N is limited to 2..8.
    localparam int MAX_N = 8;
    localparam int MAX_W = 64;

    // Index width for ptr and last_id; a 2-requester arbiter still needs one bit.
    function automatic int idx_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    // Returns requester i's data word (width w) from a packed bus, LSB-aligned.
    function automatic logic [MAX_W-1:0] din_slice(
        input logic [MAX_N*MAX_W-1:0] din,
        input int                     i,
        input int                     w
    );
        return MAX_W'(din >> (i * w));
    endfunction

endpackage

// File: rtl/rr_reg_arbiter_if.sv
// Requester-side bus of the round-robin register arbiter: requests and data in,
// grant/ack and the shared register state out.
interface rr_reg_arbiter_if
    import rr_reg_arbiter_pkg::*;
#(
    parameter int N      = N_DEF,
    parameter int DATA_W = W_DEF
);
    localparam int IW = idx_w(N);

    logic [N-1:0]        req;
    logic [N*DATA_W-1:0] din;
    logic [N-1:0]        gnt;
    logic [DATA_W-1:0]   Q;
    logic                valid;
    logic [IW-1:0]       last_id;

    modport master (
        output req, din,
        input  gnt, Q, valid, last_id
    );

    modport slave (
        input  req, din,
        output gnt, Q, valid, last_id
    );

endinterface

// File: rtl/rr_reg_arbiter_pick.sv
// Combinational round-robin winner selection: rotate the eligible vector so ptr
// sits at bit 0, take the lowest set bit, then map that position back.
module rr_pick
    import rr_reg_arbiter_pkg::*;
#(
    parameter int N  = N_DEF,
    parameter int IW = idx_w(N)
) (
    input  logic [N-1:0]  elig,
    input  logic [IW-1:0] ptr,
    output logic [IW-1:0] win,
    output logic          any
);

    logic [N-1:0]  rot;
    logic [IW-1:0] first;
    logic          found;
    int            src;
    int            sum;

    always_comb begin
        rot   = '0;
        first = '0;
        found = 1'b0;
        src   = 0;
        sum   = 0;

        for (int i = 0; i < N; i++) begin
            src = i + int'(ptr);
            if (src >= N) src = src - N;
            rot[i] = elig[src];
        end

        for (int i = 0; i < N; i++) begin
            if (!found && rot[i]) begin
                first = IW'(i);
                found = 1'b1;
            end
        end

        // Rotated position i corresponds to requester (i + ptr) mod N.
        sum = int'(first) + int'(ptr);
        if (sum >= N) sum = sum - N;
        win = IW'(sum);
    end

    assign any = |elig;

endmodule

// File: rtl/rr_reg_arbiter.sv
// Round-robin write arbiter in front of a shared W-bit register: one winner per
// cycle loads its data, receives a one-cycle grant, and the pointer moves past it.
import rr_reg_arbiter_pkg::*;

module rr_reg_arbiter #(
    parameter int N      = N_DEF,
    parameter int DATA_W = W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    rr_reg_arbiter_if.slave  bus
);

    localparam int IW = idx_w(N);

    logic [N-1:0]             gnt_p1;
    logic [DATA_W-1:0]        q_p1;
    logic                     vld_p1;
    logic [IW-1:0]            last_p1;
    logic [IW-1:0]            ptr_p1;

    logic [N-1:0]             elig_p0;
    logic [N-1:0]             onehot_p0;
    logic [IW-1:0]            win_p0;
    logic                     any_p0;
    logic [IW-1:0]            ptr_nxt_p0;
    logic [MAX_N*MAX_W-1:0]   din_ext_p0;
    logic [MAX_W-1:0]         slice_p0;
    logic [DATA_W-1:0]        data_p0;
    logic                     unused_slice_p0;

    // ---- p0: eligibility, winner pick and data select ----
    // The requester acked this cycle is masked so it can drop req without a second grant.
    assign elig_p0 = bus.req & ~gnt_p1;

    rr_pick #(
        .N  (N),
        .IW (IW)
    ) u_pick (
        .elig (elig_p0),
        .ptr  (ptr_p1),
        .win  (win_p0),
        .any  (any_p0)
    );

    always_comb begin
        din_ext_p0                  = '0;
        din_ext_p0[N*DATA_W-1:0]    = bus.din;
        slice_p0                    = din_slice(din_ext_p0, int'(win_p0), DATA_W);
        data_p0                     = slice_p0[DATA_W-1:0];

        onehot_p0                   = '0;
        onehot_p0[win_p0]           = 1'b1;

        ptr_nxt_p0 = (int'(win_p0) == N - 1) ? '0 : win_p0 + 1'b1;
    end

    assign unused_slice_p0 = ^slice_p0;

    // ---- p1: shared register, grant and bookkeeping ----
    always_ff @(posedge clk) begin
        if (rst) begin
            gnt_p1  <= '0;
            q_p1    <= '0;
            vld_p1  <= 1'b0;
            last_p1 <= '0;
            ptr_p1  <= '0;
        end else if (any_p0) begin
            gnt_p1  <= onehot_p0;
            q_p1    <= data_p0;
            vld_p1  <= 1'b1;
            last_p1 <= win_p0;
            ptr_p1  <= ptr_nxt_p0;
        end else begin
            gnt_p1  <= '0;
        end
    end

    assign bus.gnt     = gnt_p1;
    assign bus.Q       = q_p1;
    assign bus.valid   = vld_p1;
    assign bus.last_id = last_p1;

    a_gnt_onehot0: assert property (@(posedge clk) $onehot0(gnt_p1));

    a_gnt_no_repeat: assert property (@(posedge clk) disable iff (rst)
        (gnt_p1 & $past(gnt_p1)) == '0);

    a_q_only_on_grant: assert property (@(posedge clk) disable iff (rst)
        (!$past(rst) && (q_p1 != $past(q_p1))) |-> (gnt_p1 != '0));

    a_ptr_in_range: assert property (@(posedge clk) int'(ptr_p1) < N);

endmodule

// File: tb/tb_rr_reg_arbiter.sv
// Directed bench for rr_reg_arbiter (N=4, W=8): a vector table for the basic
// patterns plus hand-written sequences for wrap, mid-stream reset and idle hold.
module tb_rr_reg_arbiter;

    localparam int N  = 4;
    localparam int DW = 8;

    logic clk = 1'b0;
    logic rst;

    rr_reg_arbiter_if #(.N(N), .DATA_W(DW)) bus ();

    rr_reg_arbiter #(.N(N), .DATA_W(DW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        r_in;
        logic [3:0]  req;
        logic [31:0] din;
        logic [3:0]  gnt;
        logic [7:0]  q;
        logic        valid;
        logic [1:0]  last;
    } vec_t;

    localparam logic [31:0] D_SEQ  = 32'h13121110;
    localparam logic [31:0] D_ONE  = 32'h000000A5;
    localparam logic [31:0] D_HOLD = 32'h133C1110;
    localparam logic [31:0] D_WRAP = 32'h55000066;
    localparam logic [31:0] D_IDLE = 32'h13771110;

    vec_t vecs [16];
    int   checks = 0;
    int   errors = 0;

    function automatic vec_t mk(logic r, logic [3:0] rq, logic [31:0] d,
                                logic [3:0] g, logic [7:0] q, logic v, logic [1:0] l);
        return '{r, rq, d, g, q, v, l};
    endfunction

    task automatic check(string name, string tag, int idx, logic [31:0] got, logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s %s step %0d: got %0h want %0h", tag, name, idx, got, want);
        end
    endtask

    // Drive on the falling edge, sample just after the rising edge.
    task automatic step(string tag, int idx, vec_t v);
        @(negedge clk);
        rst     = v.r_in;
        bus.req = v.req;
        bus.din = v.din;
        @(posedge clk);
        #1;
        check("gnt",     tag, idx, 32'(bus.gnt),     32'(v.gnt));
        check("Q",       tag, idx, 32'(bus.Q),       32'(v.q));
        check("valid",   tag, idx, 32'(bus.valid),   32'(v.valid));
        check("last_id", tag, idx, 32'(bus.last_id), 32'(v.last));
    endtask

    initial begin
        rst     = 1'b1;
        bus.req = '0;
        bus.din = '0;

        // Reset, then a single request from requester 0.
        vecs[0]  = mk(1'b1, 4'b0000, D_ONE,  4'b0000, 8'h00, 1'b0, 2'd0);
        vecs[1]  = mk(1'b0, 4'b0001, D_ONE,  4'b0001, 8'hA5, 1'b1, 2'd0);
        vecs[2]  = mk(1'b0, 4'b0000, D_ONE,  4'b0000, 8'hA5, 1'b1, 2'd0);
        // All four requesting continuously from reset.
        vecs[3]  = mk(1'b1, 4'b0000, D_SEQ,  4'b0000, 8'h00, 1'b0, 2'd0);
        vecs[4]  = mk(1'b0, 4'b1111, D_SEQ,  4'b0001, 8'h10, 1'b1, 2'd0);
        vecs[5]  = mk(1'b0, 4'b1111, D_SEQ,  4'b0010, 8'h11, 1'b1, 2'd1);
        vecs[6]  = mk(1'b0, 4'b1111, D_SEQ,  4'b0100, 8'h12, 1'b1, 2'd2);
        vecs[7]  = mk(1'b0, 4'b1111, D_SEQ,  4'b1000, 8'h13, 1'b1, 2'd3);
        vecs[8]  = mk(1'b0, 4'b1111, D_SEQ,  4'b0001, 8'h10, 1'b1, 2'd0);
        // Requester 2 alone holding req for six cycles.
        vecs[9]  = mk(1'b1, 4'b0000, D_HOLD, 4'b0000, 8'h00, 1'b0, 2'd0);
        vecs[10] = mk(1'b0, 4'b0100, D_HOLD, 4'b0100, 8'h3C, 1'b1, 2'd2);
        vecs[11] = mk(1'b0, 4'b0100, D_HOLD, 4'b0000, 8'h3C, 1'b1, 2'd2);
        vecs[12] = mk(1'b0, 4'b0100, D_HOLD, 4'b0100, 8'h3C, 1'b1, 2'd2);
        vecs[13] = mk(1'b0, 4'b0100, D_HOLD, 4'b0000, 8'h3C, 1'b1, 2'd2);
        vecs[14] = mk(1'b0, 4'b0100, D_HOLD, 4'b0100, 8'h3C, 1'b1, 2'd2);
        vecs[15] = mk(1'b0, 4'b0100, D_HOLD, 4'b0000, 8'h3C, 1'b1, 2'd2);

        for (int i = 0; i < 16; i++) step("table", i, vecs[i]);

        // Pointer wrap: 3 wins, idle, then 0 beats 3 because ptr wrapped to 0.
        step("wrap", 0, mk(1'b0, 4'b1000, D_WRAP, 4'b1000, 8'h55, 1'b1, 2'd3));
        step("wrap", 1, mk(1'b0, 4'b0000, D_WRAP, 4'b0000, 8'h55, 1'b1, 2'd3));
        step("wrap", 2, mk(1'b0, 4'b1001, D_WRAP, 4'b0001, 8'h66, 1'b1, 2'd0));
        step("wrap", 3, mk(1'b0, 4'b1000, D_WRAP, 4'b1000, 8'h55, 1'b1, 2'd3));

        // Reset in the middle of a stream; first grant afterwards goes to 0.
        step("rstmid", 0, mk(1'b0, 4'b1111, D_SEQ, 4'b0001, 8'h10, 1'b1, 2'd0));
        step("rstmid", 1, mk(1'b0, 4'b1111, D_SEQ, 4'b0010, 8'h11, 1'b1, 2'd1));
        step("rstmid", 2, mk(1'b1, 4'b1111, D_SEQ, 4'b0000, 8'h00, 1'b0, 2'd0));
        step("rstmid", 3, mk(1'b0, 4'b1111, D_SEQ, 4'b0001, 8'h10, 1'b1, 2'd0));
        step("rstmid", 4, mk(1'b0, 4'b1111, D_SEQ, 4'b0010, 8'h11, 1'b1, 2'd1));

        // Write 0x77 from requester 2, then five idle cycles hold everything.
        step("idle", 0, mk(1'b0, 4'b0000, D_IDLE, 4'b0000, 8'h11, 1'b1, 2'd1));
        step("idle", 1, mk(1'b0, 4'b0100, D_IDLE, 4'b0100, 8'h77, 1'b1, 2'd2));
        for (int k = 2; k < 7; k++)
            step("idle", k, mk(1'b0, 4'b0000, D_IDLE, 4'b0000, 8'h77, 1'b1, 2'd2));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
